// File: rtl/jk_pkg.sv
// Shared definitions for the JK sequence driver: FSM state codes and default sizing.
package jk_pkg;

   localparam int unsigned JK_WIDTH_DEF     = 4;
   localparam int unsigned JK_MAX_RETRY_DEF = 2;

   typedef logic [2:0] jk_state_t;

   localparam jk_state_t ST_IDLE  = 3'd0;
   localparam jk_state_t ST_DRIVE = 3'd1;
   localparam jk_state_t ST_CHECK = 3'd2;
   localparam jk_state_t ST_DONE  = 3'd3;
   localparam jk_state_t ST_ERR   = 3'd4;

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation from current Q towards a target bit.
// JK_TOGGLE_EN selects toggle excitation instead of set/reset excitation.
module jk_excite_bit
   import jk_pkg::*;
(
   input  logic q,
   input  logic target,
   output logic j,
   output logic k
);

`ifdef JK_TOGGLE_EN
   assign j = q ^ target;
   assign k = q ^ target;
`else
   // don't-care excitation terms resolved to 0
   assign j = ~q & target;
   assign k = q & ~target;
`endif

endmodule

// File: rtl/jk_seq_driver.sv
// Drives an external JK register to a requested word, verifies it via q_fb and re-drives
// up to MAX_RETRY times. Optional macro JK_TOGGLE_EN selects toggle excitation.
module jk_seq_driver
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH     = JK_WIDTH_DEF,
   parameter int unsigned MAX_RETRY = JK_MAX_RETRY_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             done,
   output logic             err
);

   localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   jk_state_t        state, state_nx;
   logic [WIDTH-1:0] tgt_q, tgt_nx, tgt_sel;
   logic [WIDTH-1:0] j_exc, k_exc, j_nx, k_nx;
   logic [RW-1:0]    retry, retry_nx;
   logic             transfer;

   assign tgt_ready = rst_n & (state == ST_IDLE);
   assign transfer  = tgt_valid & tgt_ready;

   // Excitation target is the incoming word on a transfer, the latched word on a re-drive
   assign tgt_sel = (state == ST_IDLE) ? tgt_data : tgt_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_excite_bit u_bit (
         .q      (q_fb[i]),
         .target (tgt_sel[i]),
         .j      (j_exc[i]),
         .k      (k_exc[i])
      );
   end

   always_comb begin
      state_nx = state;
      tgt_nx   = tgt_q;
      retry_nx = retry;
      j_nx     = '0;
      k_nx     = '0;
      case (state)
         ST_IDLE: begin
            if (transfer) begin
               tgt_nx   = tgt_data;
               retry_nx = '0;
               if (tgt_data == q_fb) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_DRIVE;
                  j_nx     = j_exc;
                  k_nx     = k_exc;
               end
            end
         end
         ST_DRIVE: state_nx = ST_CHECK;
         ST_CHECK: begin
            if (q_fb == tgt_q) begin
               state_nx = ST_DONE;
            end else if (retry < RW'(MAX_RETRY)) begin
               state_nx = ST_DRIVE;
               retry_nx = retry + 1'b1;
               j_nx     = j_exc;
               k_nx     = k_exc;
            end else begin
               state_nx = ST_ERR;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         ST_ERR:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         tgt_q <= '0;
         retry <= '0;
         j     <= '0;
         k     <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         tgt_q <= tgt_nx;
         retry <= retry_nx;
         j     <= j_nx;
         k     <= k_nx;
         done  <= (state_nx == ST_DONE);
         err   <= (state_nx == ST_ERR);
      end
   end

endmodule
